npc_ctrl: RTL and testbench



---
 rtl/npc_ctrl_pkg.sv | 21 ++
 rtl/npc_ctrl_if.sv | 31 +++
 rtl/npc_ctrl_timeout.sv | 38 +++
 rtl/npc_ctrl.sv | 137 +++++++++++++
 tb/tb_npc_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/npc_ctrl_pkg.sv
// Shared encodings for the NPC sequencing controller: FSM state codes, halt
// reasons and the default bus-response timeout.
package npc_ctrl_pkg;

   localparam int unsigned CtrlStateWidth = 3;
   localparam int unsigned HaltCodeWidth  = 2;
   localparam int unsigned DefaultTimeout = 255;

   localparam logic [CtrlStateWidth-1:0] StIdle   = 3'd0;
   localparam logic [CtrlStateWidth-1:0] StFetch  = 3'd1;
   localparam logic [CtrlStateWidth-1:0] StDecode = 3'd2;
   localparam logic [CtrlStateWidth-1:0] StExec   = 3'd3;
   localparam logic [CtrlStateWidth-1:0] StMem    = 3'd4;
   localparam logic [CtrlStateWidth-1:0] StHalt   = 3'd5;

   localparam logic [HaltCodeWidth-1:0] HaltNone    = 2'd0;
   localparam logic [HaltCodeWidth-1:0] HaltEbreak  = 2'd1;
   localparam logic [HaltCodeWidth-1:0] HaltIllegal = 2'd2;
   localparam logic [HaltCodeWidth-1:0] HaltTimeout = 2'd3;

endpackage

// File: rtl/npc_ctrl_if.sv
// Handshake bundle between the controller and the IFU, decoder, LSU, register
// file and PC. The controller takes the master view.
interface npc_ctrl_if;

   logic ifu_req;
   logic ifu_rsp_valid;
   logic inst_en;
   logic dec_is_load;
   logic dec_is_store;
   logic dec_is_ebreak;
   logic dec_illegal;
   logic dec_has_rd;
   logic lsu_req;
   logic lsu_we;
   logic lsu_rsp_valid;
   logic rf_wen;
   logic pc_wen;

   modport master (
      output ifu_req, inst_en, lsu_req, lsu_we, rf_wen, pc_wen,
      input  ifu_rsp_valid, lsu_rsp_valid,
      input  dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal, dec_has_rd
   );

   modport slave (
      input  ifu_req, inst_en, lsu_req, lsu_we, rf_wen, pc_wen,
      output ifu_rsp_valid, lsu_rsp_valid,
      output dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal, dec_has_rd
   );

endinterface

// File: rtl/npc_ctrl_timeout.sv
// Wait-cycle counter: cleared while not waiting, counts waiting cycles and
// flags expiry on the TIMEOUT-th consecutive waiting cycle.
module npc_ctrl_timeout #(
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned TO_WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [TO_WIDTH-1:0] LastCnt = TO_WIDTH'(TIMEOUT - 1);

   logic [TO_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + TO_WIDTH'(1);
      end
   end

   // The current waiting cycle is the TIMEOUT-th when the count already holds TIMEOUT-1.
   assign expire_o = en_i && !clr_i && (cnt_q == LastCnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/npc_ctrl.sv
// Multi-cycle sequencer for the single-issue NPC core: fetch, decode,
// execute/memory, writeback; parks in HALT on ebreak, illegal or bus timeout.
module npc_ctrl
   import npc_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT   = DefaultTimeout,
   parameter int unsigned TO_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   npc_ctrl_if.master                bus,
   output logic                      halt,
   output logic [HaltCodeWidth-1:0]  halt_code,
   output logic [CtrlStateWidth-1:0] state,
   output logic [CNT_WIDTH-1:0]      inst_cnt
);

   logic [CtrlStateWidth-1:0] state_q, state_d;
   logic [HaltCodeWidth-1:0]  halt_code_q, halt_code_d;
   logic [CNT_WIDTH-1:0]      inst_cnt_q, inst_cnt_d;
   logic                      lsu_we_q, lsu_we_d;
   logic                      has_rd_q, has_rd_d;
   logic                      to_wait;
   logic                      to_expire;

   assign to_wait = ((state_q == StFetch) && !bus.ifu_rsp_valid) ||
                    ((state_q == StMem) && !bus.lsu_rsp_valid);

   npc_ctrl_timeout #(
      .TIMEOUT  (TIMEOUT),
      .TO_WIDTH (TO_WIDTH)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (!to_wait),
      .en_i     (to_wait),
      .expire_o (to_expire)
   );

   always_comb begin
      state_d     = state_q;
      halt_code_d = halt_code_q;
      inst_cnt_d  = inst_cnt_q;
      lsu_we_d    = lsu_we_q;
      has_rd_d    = has_rd_q;
      bus.ifu_req = 1'b0;
      bus.inst_en = 1'b0;
      bus.lsu_req = 1'b0;
      bus.lsu_we  = 1'b0;
      bus.rf_wen  = 1'b0;
      bus.pc_wen  = 1'b0;

      case (state_q)
         StIdle: state_d = StFetch;

         StFetch: begin
            bus.ifu_req = 1'b1;
            if (bus.ifu_rsp_valid) begin
               bus.inst_en = 1'b1;
               state_d     = StDecode;
            end else if (to_expire) begin
               state_d     = StHalt;
               halt_code_d = HaltTimeout;
            end
         end

         StDecode: begin
            // Load+store together is not a real encoding; treat it as illegal.
            if (bus.dec_illegal || (bus.dec_is_load && bus.dec_is_store)) begin
               state_d     = StHalt;
               halt_code_d = HaltIllegal;
            end else if (bus.dec_is_ebreak) begin
               state_d     = StHalt;
               halt_code_d = HaltEbreak;
            end else if (bus.dec_is_load || bus.dec_is_store) begin
               state_d  = StMem;
               lsu_we_d = bus.dec_is_store;
               has_rd_d = bus.dec_has_rd;
            end else begin
               state_d  = StExec;
               has_rd_d = bus.dec_has_rd;
            end
         end

         StExec: begin
            bus.rf_wen = has_rd_q;
            bus.pc_wen = 1'b1;
            inst_cnt_d = inst_cnt_q + CNT_WIDTH'(1);
            state_d    = StFetch;
         end

         StMem: begin
            bus.lsu_req = 1'b1;
            bus.lsu_we  = lsu_we_q;
            if (bus.lsu_rsp_valid) begin
               bus.rf_wen = has_rd_q && !lsu_we_q;
               bus.pc_wen = 1'b1;
               inst_cnt_d = inst_cnt_q + CNT_WIDTH'(1);
               state_d    = StFetch;
            end else if (to_expire) begin
               state_d     = StHalt;
               halt_code_d = HaltTimeout;
            end
         end

         StHalt: state_d = StHalt;

         default: begin
            state_d     = StHalt;
            halt_code_d = HaltIllegal;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         halt_code_q <= HaltNone;
         inst_cnt_q  <= '0;
         lsu_we_q    <= 1'b0;
         has_rd_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         halt_code_q <= halt_code_d;
         inst_cnt_q  <= inst_cnt_d;
         lsu_we_q    <= lsu_we_d;
         has_rd_q    <= has_rd_d;
      end
   end

   assign halt      = (state_q == StHalt);
   assign halt_code = halt_code_q;
   assign state     = state_q;
   assign inst_cnt  = inst_cnt_q;

endmodule

// File: tb/tb_npc_ctrl.sv
// Bench for npc_ctrl: instruction-level reference model driving random and
// directed instruction streams, checked cycle by cycle.
module tb_npc_ctrl;

   localparam int unsigned TO = 4;

   localparam int KAlu     = 0;
   localparam int KLoad    = 1;
   localparam int KStore   = 2;
   localparam int KEbreak  = 3;
   localparam int KIllegal = 4;
   localparam int KLdSt    = 5;

   localparam logic [2:0] SIdle = 3'd0, SFetch = 3'd1, SDecode = 3'd2;
   localparam logic [2:0] SExec = 3'd3, SMem = 3'd4, SHalt = 3'd5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halt;
   logic [1:0]  halt_code;
   logic [2:0]  state;
   logic [31:0] inst_cnt;

   npc_ctrl_if bus ();

   npc_ctrl #(
      .TIMEOUT   (TO),
      .TO_WIDTH  (3),
      .CNT_WIDTH (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .halt      (halt),
      .halt_code (halt_code),
      .state     (state),
      .inst_cnt  (inst_cnt)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_cnt;
   logic        m_halt;
   logic [1:0]  m_code;

   function automatic logic [5:0] sb(input bit ifu, input bit ie, input bit lr,
                                     input bit lw, input bit rw, input bit pw);
      return {ifu, ie, lr, lw, rw, pw};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check one cycle's outputs at the negedge, then advance to just after the next posedge.
   task automatic cyc(input string tag, input logic [5:0] exp_strb, input logic [2:0] exp_st);
      @(negedge clk);
      chk({tag, ".strobes"}, 32'({bus.ifu_req, bus.inst_en, bus.lsu_req, bus.lsu_we,
                                  bus.rf_wen, bus.pc_wen}), 32'(exp_strb));
      chk({tag, ".state"}, 32'(state), 32'(exp_st));
      chk({tag, ".halt"}, 32'(halt), 32'(m_halt));
      chk({tag, ".halt_code"}, 32'(halt_code), 32'(m_code));
      chk({tag, ".inst_cnt"}, inst_cnt, m_cnt);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_flags();
      bus.dec_is_load   = 1'($urandom_range(0, 1));
      bus.dec_is_store  = 1'($urandom_range(0, 1));
      bus.dec_is_ebreak = 1'($urandom_range(0, 1));
      bus.dec_illegal   = 1'($urandom_range(0, 1));
      bus.dec_has_rd    = 1'($urandom_range(0, 1));
   endtask

   task automatic set_flags(input int kind, input bit rd);
      bus.dec_illegal   = (kind == KIllegal);
      bus.dec_is_ebreak = (kind == KEbreak);
      bus.dec_is_load   = (kind == KLoad) || (kind == KLdSt);
      bus.dec_is_store  = (kind == KStore) || (kind == KLdSt);
      bus.dec_has_rd    = rd;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      bus.ifu_rsp_valid = 1'b0;
      bus.lsu_rsp_valid = 1'b0;
      set_flags(KAlu, 1'b0);
      repeat (n) @(posedge clk);
      #1;
      rst    = 1'b0;
      m_cnt  = '0;
      m_halt = 1'b0;
      m_code = 2'd0;
      cyc("idle", 6'b0, SIdle);
   endtask

   // One instruction from the first FETCH cycle: fw cycles without an IFU
   // response, decode as kind, and mw cycles without an LSU response.
   task automatic run_inst(input int fw, input int kind, input bit rd, input int mw);
      bit st;
      for (int i = 0; i < fw && i < int'(TO); i++) begin
         bus.ifu_rsp_valid = 1'b0;
         bus.lsu_rsp_valid = 1'($urandom_range(0, 1));
         rand_flags();
         cyc("fetch_wait", sb(1, 0, 0, 0, 0, 0), SFetch);
      end
      if (fw >= int'(TO)) begin
         m_halt = 1'b1;
         m_code = 2'd3;
         cyc("fetch_timeout", 6'b0, SHalt);
         return;
      end
      bus.ifu_rsp_valid = 1'b1;
      bus.lsu_rsp_valid = 1'($urandom_range(0, 1));
      cyc("fetch_rsp", sb(1, 1, 0, 0, 0, 0), SFetch);

      bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
      bus.lsu_rsp_valid = 1'($urandom_range(0, 1));
      set_flags(kind, rd);
      cyc("decode", 6'b0, SDecode);

      if (kind == KEbreak || kind == KIllegal || kind == KLdSt) begin
         m_halt = 1'b1;
         m_code = (kind == KEbreak) ? 2'd1 : 2'd2;
         cyc("halt_entry", 6'b0, SHalt);
         return;
      end

      if (kind == KAlu) begin
         bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
         bus.lsu_rsp_valid = 1'($urandom_range(0, 1));
         cyc("exec", sb(0, 0, 0, 0, rd, 1), SExec);
         m_cnt++;
         return;
      end

      st = (kind == KStore);
      for (int i = 0; i < mw && i < int'(TO); i++) begin
         bus.lsu_rsp_valid = 1'b0;
         bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
         rand_flags();
         cyc("mem_wait", sb(0, 0, 1, st, 0, 0), SMem);
      end
      if (mw >= int'(TO)) begin
         m_halt = 1'b1;
         m_code = 2'd3;
         cyc("mem_timeout", 6'b0, SHalt);
         return;
      end
      bus.lsu_rsp_valid = 1'b1;
      bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
      rand_flags();
      cyc("mem_rsp", sb(0, 0, 1, st, rd && !st, 1), SMem);
      m_cnt++;
   endtask

   task automatic halt_hold(input int n);
      for (int i = 0; i < n; i++) begin
         bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
         bus.lsu_rsp_valid = 1'($urandom_range(0, 1));
         rand_flags();
         cyc("halt_hold", 6'b0, SHalt);
      end
   endtask

   initial begin
      int kind;
      do_reset(2);

      // Directed ALU, load and store with 3-cycle LSU latency
      run_inst(0, KAlu, 1'b1, 0);
      run_inst(0, KLoad, 1'b1, 2);
      run_inst(1, KStore, 1'b1, 2);
      // IFU response on the last allowed cycle wins over the timeout
      run_inst(int'(TO) - 1, KAlu, 1'b0, 0);
      run_inst(0, KLoad, 1'b1, int'(TO) - 1);

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 2);
         run_inst($urandom_range(0, TO - 1), kind, 1'($urandom_range(0, 1)),
                  $urandom_range(0, TO - 1));
      end

      run_inst(0, KEbreak, 1'b1, 0);
      halt_hold(6);

      do_reset(1);
      run_inst(int'(TO), KAlu, 1'b1, 0);
      halt_hold(3);

      do_reset(1);
      run_inst(0, KAlu, 1'b1, 0);
      run_inst(0, KStore, 1'b0, int'(TO));
      halt_hold(3);

      do_reset(1);
      run_inst(0, KIllegal, 1'b1, 0);
      halt_hold(2);

      do_reset(1);
      run_inst(0, KLdSt, 1'b1, 0);
      halt_hold(2);

      // Reset while a load is outstanding in MEM
      do_reset(1);
      run_inst(0, KAlu, 1'b1, 0);
      bus.ifu_rsp_valid = 1'b1;
      cyc("abort_fetch", sb(1, 1, 0, 0, 0, 0), SFetch);
      set_flags(KLoad, 1'b1);
      bus.ifu_rsp_valid = 1'b0;
      cyc("abort_decode", 6'b0, SDecode);
      bus.lsu_rsp_valid = 1'b0;
      cyc("abort_mem", sb(0, 0, 1, 0, 0, 0), SMem);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      m_cnt  = '0;
      m_halt = 1'b0;
      m_code = 2'd0;
      cyc("after_abort", 6'b0, SIdle);
      run_inst(0, KAlu, 1'b1, 0);
      run_inst(2, KLoad, 1'b1, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
